// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace transmitter: record type codes,
// payload word counts, header field offsets, record layout and serialiser states.
// Optional build macro: TRACE_CYCLE_STAMP_EN (adds a 32-bit capture-cycle stamp
// to every record and two extra stream words after PC).
package trace_pkg;

    // Record type codes carried in header bits [15:12]
    typedef enum logic [2:0] {
        T_NOP  = 3'd0,
        T_REG  = 3'd1,
        T_LD   = 3'd2,
        T_ST   = 3'd3,
        T_HALT = 3'd4
    } trace_type_e;

    // Header field offsets
    localparam int HDR_TYPE_LSB = 12;
    localparam int HDR_REG_LSB  = 8;
    localparam int HDR_SEQ_LSB  = 0;

    // Payload words following PC (and the stamp, when present)
    localparam logic [1:0] PAY_NOP  = 2'd0;
    localparam logic [1:0] PAY_REG  = 2'd1;
    localparam logic [1:0] PAY_LD   = 2'd2;
    localparam logic [1:0] PAY_ST   = 2'd2;
    localparam logic [1:0] PAY_HALT = 2'd0;

    function automatic logic [1:0] payload_words(input trace_type_e t);
        case (t)
            T_REG:   return PAY_REG;
            T_LD:    return PAY_LD;
            T_ST:    return PAY_ST;
            T_HALT:  return PAY_HALT;
            default: return PAY_NOP;
        endcase
    endfunction

    // One buffered record; p0/p1 are already in stream order for the type
    typedef struct packed {
        trace_type_e typ;
        logic [3:0]  wreg;
        logic [7:0]  seq;
        logic [15:0] pc;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] stamp;
`endif
        logic [15:0] p0;
        logic [15:0] p1;
    } trace_rec_t;

    // Serialiser states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_PC       = 3'd2,
`ifdef TRACE_CYCLE_STAMP_EN
        S_STAMP_HI = 3'd3,
        S_STAMP_LO = 3'd4,
`endif
        S_P0       = 3'd5,
        S_P1       = 3'd6
    } tx_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is ignored.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Next pointers, occupancy and storage contents
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: classifies each committing cycle into one
// record, buffers records and serialises them as 16-bit valid/ready words.
// Optional build macro: TRACE_CYCLE_STAMP_EN (capture-cycle stamp words).
//
// Stream handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. While tx_valid=1 and tx_ready=0, tx_valid, tx_data and
// tx_last hold. tx_valid falls only after a tx_last transfer that empties the
// FIFO; with tx_ready held high, records stream without idle cycles.
module retire_trace_tx
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CYC_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             hlt,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [15:0]      tx_data,
    output logic             tx_last,
    output logic             overflow,
    output logic [CYC_W-1:0] drop_count,
    output logic [CYC_W-1:0] inst_count,
    output logic             done,
    output tx_state_e        dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_q, state_d;
    trace_rec_t       cap_rec, push_rec, head_rec, pend_rec_q, pend_rec_d;
    logic             pend_q, pend_d;
    logic             halt_seen_q, halt_seen_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [CYC_W-1:0] inst_q, inst_d, drop_q, drop_d;
    logic             capture, push, pop, room, more;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [1:0]       npay;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    // Cycles since reset release, used as the capture stamp
    always_comb begin
        cyc_d = cyc_q + 1'b1;
    end

    // Cycle stamp counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end
`endif

    assign capture    = en & ~halt_seen_q;
    assign pop        = tx_valid & tx_ready & tx_last;
    assign room       = ~fifo_full | pop;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign inst_count = inst_q;
    assign done       = done_q;
    assign dbg_state  = state_q;
    assign npay       = payload_words(head_rec.typ);
    // Another record will be at the FIFO head after the current tx_last:
    // either one is already queued behind it, or one is pushed this cycle
    // (a push always has room in a popping cycle).
    assign more       = (fifo_count > CNT_W'(1)) | pend_q | capture;

    // Classify the committing cycle into a record (HALT > LD > REG > ST > NOP)
    always_comb begin
        cap_rec      = '0;
        cap_rec.wreg = write_reg;
        cap_rec.seq  = inst_q[7:0];
        cap_rec.pc   = pc;
`ifdef TRACE_CYCLE_STAMP_EN
        cap_rec.stamp = 32'(cyc_q);
`endif
        if (hlt) begin
            cap_rec.typ = T_HALT;
        end else if (reg_write && mem_read) begin
            cap_rec.typ = T_LD;
            cap_rec.p0  = write_data;
            cap_rec.p1  = mem_addr;
        end else if (reg_write) begin
            cap_rec.typ = T_REG;
            cap_rec.p0  = write_data;
        end else if (mem_write) begin
            cap_rec.typ = T_ST;
            cap_rec.p0  = mem_addr;
            cap_rec.p1  = mem_data;
        end else begin
            cap_rec.typ = T_NOP;
        end
    end

    // Enqueue, drop accounting, pending halt and completion tracking
    always_comb begin
        push        = 1'b0;
        push_rec    = cap_rec;
        pend_d      = pend_q;
        pend_rec_d  = pend_rec_q;
        halt_seen_d = halt_seen_q;
        overflow_d  = overflow_q;
        inst_d      = inst_q;
        drop_d      = drop_q;
        done_d      = done_q;
        if (pend_q) begin
            // Captures are frozen once halt is seen, so only the halt moves
            push     = room;
            push_rec = pend_rec_q;
            if (room) pend_d = 1'b0;
        end else if (capture) begin
            inst_d = inst_q + 1'b1;
            if (cap_rec.typ == T_HALT) begin
                halt_seen_d = 1'b1;
                push        = room;
                if (!room) begin
                    pend_d     = 1'b1;
                    pend_rec_d = cap_rec;
                end
            end else if (room) begin
                push = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
        if (pop && head_rec.typ == T_HALT) done_d = 1'b1;
    end

    // Serialiser: word selection, last flag and next state
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q || capture) state_d = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data[HDR_TYPE_LSB +: 4] = {1'b0, head_rec.typ};
                tx_data[HDR_REG_LSB  +: 4] = head_rec.wreg;
                tx_data[HDR_SEQ_LSB  +: 8] = head_rec.seq;
                if (tx_ready) state_d = S_PC;
            end
`ifdef TRACE_CYCLE_STAMP_EN
            S_PC: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.pc;
                if (tx_ready) state_d = S_STAMP_HI;
            end
            S_STAMP_HI: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.stamp[31:16];
                if (tx_ready) state_d = S_STAMP_LO;
            end
            S_STAMP_LO: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.stamp[15:0];
                tx_last  = (npay == 2'd0);
                if (tx_ready) state_d = (npay == 2'd0) ? (more ? S_HDR : S_IDLE) : S_P0;
            end
`else
            S_PC: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.pc;
                tx_last  = (npay == 2'd0);
                if (tx_ready) state_d = (npay == 2'd0) ? (more ? S_HDR : S_IDLE) : S_P0;
            end
`endif
            S_P0: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.p0;
                tx_last  = (npay == 2'd1);
                if (tx_ready) state_d = (npay == 2'd1) ? (more ? S_HDR : S_IDLE) : S_P1;
            end
            S_P1: begin
                tx_valid = 1'b1;
                tx_data  = head_rec.p1;
                tx_last  = 1'b1;
                if (tx_ready) state_d = more ? S_HDR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            pend_rec_q  <= '0;
            halt_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            inst_q      <= '0;
            drop_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_rec_q  <= pend_rec_d;
            halt_seen_q <= halt_seen_d;
            overflow_q  <= overflow_d;
            inst_q      <= inst_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
        end
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Emptiness is implied by the FSM returning to idle; kept for observability
    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed self-checking bench for retire_trace_tx.
// Optional build macro: TRACE_CYCLE_STAMP_EN (runs the cycle-stamp scenario).
module tb_retire_trace_tx;
    import trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, reg_write, mem_read, mem_write, hlt, tx_ready;
    logic [15:0]   pc, write_data, mem_addr, mem_data;
    logic [3:0]    write_reg;
    logic          tx_valid, tx_last, overflow, done;
    logic [15:0]   tx_data;
    logic [CW-1:0] drop_count, inst_count;
    tx_state_e     dbg_state;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [15:0]   got_d[$];
    logic          got_l[$];

    retire_trace_tx #(.FIFO_DEPTH(DEPTH), .CYC_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pc         (pc),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .hlt        (hlt),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .overflow   (overflow),
        .drop_count (drop_count),
        .inst_count (inst_count),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 0; reg_write = 0; mem_read = 0; mem_write = 0; hlt = 0;
        pc = '0; write_reg = '0; write_data = '0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic drive_reg(input logic [15:0] p, input logic [3:0] r, input logic [15:0] d);
        idle_inputs();
        en = 1; reg_write = 1; pc = p; write_reg = r; write_data = d;
        tick();
        idle_inputs();
    endtask

    // Collect transferred words until n are seen or the cycle budget expires
    task automatic recv(input int n, input int budget, output int cycles);
        got_d.delete();
        got_l.delete();
        cycles = 0;
        while (got_d.size() < n && cycles < budget) begin
            if (tx_valid && tx_ready) begin
                got_d.push_back(tx_data);
                got_l.push_back(tx_last);
            end
            tick();
            cycles++;
        end
        if (got_d.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL recv_timeout: got %0d words, need %0d", got_d.size(), n);
        end
    endtask

    task automatic test_reset();
        tx_ready = 0;
        apply_reset();
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 16'h0 || tx_last !== 1'b0 || overflow !== 1'b0 ||
            drop_count !== '0 || inst_count !== '0 || done !== 1'b0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h last=%b ovf=%b drop=%0d inst=%0d done=%b st=%0d, need all zero/IDLE",
                     tx_valid, tx_data, tx_last, overflow, drop_count, inst_count, done, dbg_state);
        end
    endtask

    task automatic test_reg_record();
        logic [15:0] exp_d [3];
        int cyc;
        exp_d = '{16'h1300, 16'h0002, 16'h00AB};
        apply_reset();
        tx_ready = 1;
        drive_reg(16'h0002, 4'd3, 16'h00AB);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h1300) begin
            n_fail++;
            $display("FAIL reg_latency: valid=%b data=%h, need 1 1300", tx_valid, tx_data);
        end
        recv(3, 20, cyc);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL reg_word%0d: got %h last=%b, need %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
            end
        end
        n_tests++;
        if (tx_valid !== 1'b0 || inst_count !== 32'd1) begin
            n_fail++;
            $display("FAIL reg_after: valid=%b inst=%0d, need 0 1", tx_valid, inst_count);
        end
    endtask

    task automatic test_store_backpressure();
        logic [15:0] exp_d [4];
        logic [15:0] prev_d;
        logic        prev_l, prev_stall, tgl;
        int          cyc;
        exp_d = '{16'h3000, 16'h0010, 16'h0040, 16'hBEEF};
        tx_ready = 0;
        apply_reset();
        en = 1; mem_write = 1; pc = 16'h0010; mem_addr = 16'h0040; mem_data = 16'hBEEF;
        tick();
        idle_inputs();
        got_d.delete(); got_l.delete();
        prev_stall = 0; prev_d = '0; prev_l = 0; tgl = 0; cyc = 0;
        while (got_d.size() < 4 && cyc < 40) begin
            tx_ready = tgl;
            tgl = ~tgl;
            if (prev_stall) begin
                n_tests++;
                if (tx_valid !== 1'b1 || tx_data !== prev_d || tx_last !== prev_l) begin
                    n_fail++;
                    $display("FAIL st_stable: valid=%b data=%h last=%b, need 1 %h %b", tx_valid, tx_data, tx_last, prev_d, prev_l);
                end
            end
            if (tx_valid && tx_ready) begin
                got_d.push_back(tx_data);
                got_l.push_back(tx_last);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_d = tx_data;
            prev_l = tx_last;
            tick();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL st_word%0d: got %h last=%b, need %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        tx_ready = 0;
        apply_reset();
        for (int i = 0; i < DEPTH + 3; i++) drive_reg(16'h0100 + 16'(i), 4'd1, 16'h00A0 + 16'(i));
        n_tests++;
        if (overflow !== 1'b1 || drop_count !== 32'd3 || inst_count !== 32'(DEPTH + 3)) begin
            n_fail++;
            $display("FAIL ovf_counts: ovf=%b drop=%0d inst=%0d, need 1 3 %0d", overflow, drop_count, inst_count, DEPTH + 3);
        end
        tx_ready = 1;
        recv(3 * DEPTH, 100, cyc);
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (got_d[3*i] !== (16'h1100 | 16'(i)) || got_d[3*i+1] !== 16'h0100 + 16'(i) ||
                got_d[3*i+2] !== 16'h00A0 + 16'(i) || got_l[3*i+2] !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_rec%0d: got %h %h %h last=%b, need %h %h %h 1", i, got_d[3*i], got_d[3*i+1],
                         got_d[3*i+2], got_l[3*i+2], 16'h1100 | 16'(i), 16'h0100 + 16'(i), 16'h00A0 + 16'(i));
            end
        end
        n_tests++;
        if (cyc !== 3 * DEPTH || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain: cycles=%0d valid=%b, need %0d 0", cyc, tx_valid, 3 * DEPTH);
        end
    endtask

    task automatic test_halt_full();
        int cyc;
        tx_ready = 0;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) drive_reg(16'h0200 + 16'(i), 4'd2, 16'h0010 + 16'(i));
        en = 1; hlt = 1; pc = 16'h0300;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) drive_reg(16'h0400, 4'd9, 16'hDEAD);
        n_tests++;
        if (inst_count !== 32'd9 || drop_count !== '0 || overflow !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_counts: inst=%0d drop=%0d ovf=%b done=%b, need 9 0 0 0", inst_count, drop_count, overflow, done);
        end
        tx_ready = 1;
        recv(3 * DEPTH + 2, 100, cyc);
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (got_d[3*i] !== (16'h1200 | 16'(i))) begin
                n_fail++;
                $display("FAIL halt_prior%0d: got %h, need %h", i, got_d[3*i], 16'h1200 | 16'(i));
            end
        end
        n_tests++;
        if (got_d[3*DEPTH] !== 16'h4008 || got_d[3*DEPTH+1] !== 16'h0300 ||
            got_l[3*DEPTH] !== 1'b0 || got_l[3*DEPTH+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_words: got %h %h last=%b%b, need 4008 0300 last=01", got_d[3*DEPTH],
                     got_d[3*DEPTH+1], got_l[3*DEPTH], got_l[3*DEPTH+1]);
        end
        n_tests++;
        if (done !== 1'b1 || tx_valid !== 1'b0 || inst_count !== 32'd9) begin
            n_fail++;
            $display("FAIL halt_done: done=%b valid=%b inst=%0d, need 1 0 9", done, tx_valid, inst_count);
        end
        repeat (3) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_done_hold: done=%b, need 1", done);
        end
    endtask

    task automatic test_reset_mid_record();
        logic [15:0] exp_d [3];
        int cyc;
        exp_d = '{16'h1700, 16'h0030, 16'h5555};
        tx_ready = 1;
        apply_reset();
        en = 1; reg_write = 1; mem_read = 1; write_reg = 4'd5; write_data = 16'h1234;
        mem_addr = 16'h0080; pc = 16'h0020;
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h0020) begin
            n_fail++;
            $display("FAIL ld_pc_word: valid=%b data=%h, need 1 0020", tx_valid, tx_data);
        end
        rst_n = 0;
        tick();
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 16'h0 || inst_count !== '0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h inst=%0d st=%0d, need 0 0000 0 IDLE", tx_valid, tx_data, inst_count, dbg_state);
        end
        rst_n = 1;
        drive_reg(16'h0030, 4'd7, 16'h5555);
        recv(3, 20, cyc);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL post_reset_word%0d: got %h last=%b, need %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [6];
        logic        exp_l [6];
        int cyc;
        exp_d = '{16'h0000, 16'h0050, 16'h3001, 16'h0060, 16'h0070, 16'h0080};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tx_ready = 0;
        apply_reset();
        en = 1; pc = 16'h0050;
        tick();
        idle_inputs();
        en = 1; mem_write = 1; pc = 16'h0060; mem_addr = 16'h0070; mem_data = 16'h0080;
        tick();
        idle_inputs();
        tx_ready = 1;
        recv(6, 30, cyc);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h last=%b, need %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_tests++;
        if (cyc !== 6) begin
            n_fail++;
            $display("FAIL b2b_bubbles: cycles=%0d, need 6", cyc);
        end
    endtask

`ifdef TRACE_CYCLE_STAMP_EN
    task automatic test_cycle_stamp();
        logic [15:0] exp_d [4];
        int cyc;
        exp_d = '{16'h0000, 16'h0044, 16'h0000, 16'h0004};
        tx_ready = 0;
        apply_reset();
        repeat (4) tick();
        en = 1; pc = 16'h0044;
        tick();
        idle_inputs();
        tx_ready = 1;
        recv(4, 20, cyc);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL stamp_word%0d: got %h last=%b, need %h last=%b", i, got_d[i], got_l[i], exp_d[i], (i == 3));
            end
        end
    endtask
`endif

    initial begin
        rst_n = 0;
        tx_ready = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
`ifdef TRACE_CYCLE_STAMP_EN
        test_cycle_stamp();
`else
        test_reg_record();
        test_store_backpressure();
        test_overflow();
        test_halt_full();
        test_reset_mid_record();
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
